// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetch sequencer.
// Issues one fetch at a time and holds the word until the core retires it.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  next_pc_select,
  input  logic        pc_update,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic [31:0] trap_vector,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [31:0] fetch_addr,
  input  logic        fetch_rsp_valid,
  input  logic [31:0] fetch_rsp_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        misaligned_target
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] trap_base;
  logic [31:0] target;
  logic        target_bad;

  assign pc_plus_4  = pc + 32'd4;
  assign fetch_addr = pc;
  assign trap_base  = {trap_vector[31:2], 2'b00};

  always_comb begin
    target = pc_plus_4;
    unique case (next_pc_select)
      2'b00:   target = pc_plus_4;
      2'b01:   target = branch_target;
      2'b10:   target = {jalr_target[31:1], 1'b0};
      default: target = trap_base;
    endcase
    // Trap vector is pre-aligned, so only the other sources can fault.
    target_bad = (next_pc_select != 2'b11) && target[1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_REQ;
      pc                <= RESET_VECTOR;
      inst              <= 32'd0;
      inst_valid        <= 1'b0;
      misaligned_target <= 1'b0;
      fetch_req_valid   <= 1'b1;
    end else begin
      misaligned_target <= 1'b0;
      unique case (state)
        S_REQ: begin
          if (fetch_req_ready) begin
            state           <= S_WAIT;
            fetch_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (fetch_rsp_valid) begin
            state      <= S_HOLD;
            inst       <= fetch_rsp_data;
            inst_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (pc_update) begin
            state             <= S_REQ;
            inst_valid        <= 1'b0;
            fetch_req_valid   <= 1'b1;
            pc                <= target_bad ? trap_base : target;
            misaligned_target <= target_bad;
          end
        end
        default: begin
          state           <= S_REQ;
          fetch_req_valid <= 1'b1;
          inst_valid      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a cycle-level reference model
// compared on every falling edge.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  next_pc_select = 2'b00;
  logic        pc_update = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] jalr_target = 32'd0;
  logic [31:0] trap_vector = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        fetch_req_valid;
  logic        fetch_req_ready = 1'b0;
  logic [31:0] fetch_addr;
  logic        fetch_rsp_valid = 1'b0;
  logic [31:0] fetch_rsp_data = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misaligned_target;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clock(clock),
    .reset(reset),
    .next_pc_select(next_pc_select),
    .pc_update(pc_update),
    .branch_target(branch_target),
    .jalr_target(jalr_target),
    .trap_vector(trap_vector),
    .pc(pc),
    .pc_plus_4(pc_plus_4),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_ready(fetch_req_ready),
    .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_data(fetch_rsp_data),
    .inst(inst),
    .inst_valid(inst_valid),
    .misaligned_target(misaligned_target)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = request outstanding, 1 = awaiting word,
  // 2 = word held for the core.
  int          m_phase = 0;
  logic [31:0] m_pc = RV;
  logic [31:0] m_inst = 32'd0;
  logic        m_iv = 1'b0;
  logic        m_mis = 1'b0;
  bit          m_on = 1'b0;

  function automatic logic [31:0] pick(input logic [1:0] s,
                                       input logic [31:0] cur);
    case (s)
      2'd0:    return cur + 32'd4;
      2'd1:    return branch_target;
      2'd2:    return jalr_target & ~32'd1;
      default: return trap_vector & ~32'd3;
    endcase
  endfunction

  always @(posedge clock) begin
    logic [31:0] t;
    if (reset) begin
      m_phase = 0; m_pc = RV; m_inst = 0; m_iv = 0; m_mis = 0;
      m_on = 1'b1;
    end else begin
      m_mis = 0;
      if (m_phase == 0) begin
        if (fetch_req_ready) m_phase = 1;
      end else if (m_phase == 1) begin
        if (fetch_rsp_valid) begin
          m_inst = fetch_rsp_data; m_iv = 1; m_phase = 2;
        end
      end else if (pc_update) begin
        t = pick(next_pc_select, m_pc);
        if (next_pc_select != 2'd3 && (t & 32'd2) != 0) begin
          m_pc = trap_vector & ~32'd3;
          m_mis = 1;
        end else begin
          m_pc = t;
        end
        m_iv = 0;
        m_phase = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      check("m_pc", pc, m_pc);
      check("m_pc4", pc_plus_4, m_pc + 32'd4);
      check("m_addr", fetch_addr, m_pc);
      check("m_reqv", {31'd0, fetch_req_valid}, {31'd0, m_phase == 0});
      check("m_inst", inst, m_inst);
      check("m_iv", {31'd0, inst_valid}, {31'd0, m_iv});
      check("m_mis", {31'd0, misaligned_target}, {31'd0, m_mis});
      check("m_excl", {31'd0, inst_valid & misaligned_target}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word);
    bit got;
    got = 1'b0;
    fetch_req_ready = 1'b1;
    fetch_rsp_valid = 1'b1;
    fetch_rsp_data  = word;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = inst_valid;
    end
    check("fetch_done", {31'd0, got}, 32'd1);
    fetch_req_ready = 1'b0;
    fetch_rsp_valid = 1'b0;
  endtask

  task automatic retire(input logic [1:0] sel);
    next_pc_select = sel;
    pc_update = 1'b1;
    step();
    pc_update = 1'b0;
  endtask

  initial begin
    fetch_req_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_addr", fetch_addr, 32'h0040_0000);
    check("rst_reqv", {31'd0, fetch_req_valid}, 32'd1);
    check("rst_iv", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    step();
    check("wait_reqv", {31'd0, fetch_req_valid}, 32'd0);
    fetch_rsp_valid = 1'b1;
    fetch_rsp_data  = 32'h0000_0013;
    step();
    fetch_rsp_valid = 1'b0;
    fetch_req_ready = 1'b0;
    check("c3_inst", inst, 32'h0000_0013);
    check("c3_iv", {31'd0, inst_valid}, 32'd1);
    retire(2'b00);
    check("seq_pc", pc, 32'h0040_0004);
    check("seq_reqv", {31'd0, fetch_req_valid}, 32'd1);

    fetch(32'h0000_0063);
    branch_target = 32'h0040_0100;
    retire(2'b01);
    check("br_pc", pc, 32'h0040_0100);

    fetch(32'h0000_0067);
    jalr_target = 32'h0040_0201;
    retire(2'b10);
    check("jalr_pc", pc, 32'h0040_0200);
    check("jalr_mis", {31'd0, misaligned_target}, 32'd0);

    fetch(32'h0000_0067);
    jalr_target = 32'h0040_0206;
    trap_vector = 32'h0000_1003;
    retire(2'b10);
    check("mis_pc", pc, 32'h0000_1000);
    check("mis_flag", {31'd0, misaligned_target}, 32'd1);
    check("mis_iv", {31'd0, inst_valid}, 32'd0);
    step();
    check("mis_drop", {31'd0, misaligned_target}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      pc_update = i[0];
      fetch_rsp_valid = ~i[0];
      step();
      check("bp_addr", fetch_addr, 32'h0000_1000);
      check("bp_pc", pc, 32'h0000_1000);
      check("bp_reqv", {31'd0, fetch_req_valid}, 32'd1);
      check("bp_iv", {31'd0, inst_valid}, 32'd0);
    end
    pc_update = 1'b0;
    fetch_rsp_valid = 1'b0;

    fetch(32'h0000_0073);
    trap_vector = 32'h0000_2002;
    retire(2'b11);
    check("trap_pc", pc, 32'h0000_2000);
    check("trap_mis", {31'd0, misaligned_target}, 32'd0);

    fetch(32'h0000_006f);
    branch_target = 32'hFFFF_FFFC;
    retire(2'b01);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_pc4", pc_plus_4, 32'h0000_0000);
    fetch(32'h0000_0013);
    retire(2'b00);
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_mis", {31'd0, misaligned_target}, 32'd0);

    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready = 1'b0;
    check("pre_rst_reqv", {31'd0, fetch_req_valid}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_pc", pc, RV);
    check("mid_rst_reqv", {31'd0, fetch_req_valid}, 32'd1);
    check("mid_rst_iv", {31'd0, inst_valid}, 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Owns the architectural program counter and drives instruction fetch for the RV32 core. It consumes the 2-bit `next_pc_select` produced by the control-transfer logic (00 = PC+4, 01 = PC+imm, 10 = jalr target, 11 = trap vector). It also runs a valid/ready request plus response handshake toward instruction memory, and presents one fetched instruction at a time to decode. The block sits between the instruction memory port and the decode/execute stage of the multi-cycle core.

## Interface
- `RESET_VECTOR`, default 32'h0040_0000: PC loaded on reset.
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `next_pc_select`  in  2: next-PC source, sampled only on an accepted `pc_update`.
- `pc_update`  in  1: pulse from core; current instruction retired, commit next PC.
- `branch_target`  in  32: PC + immediate (branch/JAL).
- `jalr_target`  in  32: rs1 + immediate, unmasked.
- `trap_vector`  in  32: machine trap base (direct mode).
- `pc`  out  32: architectural PC of the instruction being fetched or held.
- `pc_plus_4`  out  32: `pc + 4`, modulo 2^32, combinational from `pc`.
- `fetch_req_valid`  out  1: fetch request pending.
- `fetch_req_ready`  in  1: memory accepts request.
- `fetch_addr`  out  32: equals `pc`.
- `fetch_rsp_valid`  in  1: memory returns instruction word.
- `fetch_rsp_data`  in  32: instruction word.
- `inst`  out  32: held instruction.
- `inst_valid`  out  1: `inst` valid, awaiting `pc_update`.
- `misaligned_target`  out  1: one-cycle pulse, selected target not 4-byte aligned.

## Operation
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - `fetch_req_valid`=1, `fetch_addr`=`pc` held stable.
  - Moves to WAIT on `fetch_req_valid && fetch_req_ready`.
  - `fetch_rsp_valid` is ignored in REQ.
- WAIT:
  - `fetch_req_valid`=0.
  - On `fetch_rsp_valid`: `inst` <= `fetch_rsp_data`, `inst_valid` <= 1, go to HOLD.
- HOLD:
  - `inst`/`inst_valid` held until `pc_update`.
  - On `pc_update`: compute target, load `pc`, clear `inst_valid`, go to REQ.
  - `fetch_rsp_valid` is ignored in HOLD.
- `pc_update` outside HOLD is ignored; `pc` is unchanged.
- Target selection:
  - 00: `pc + 4`.
  - 01: `branch_target`.
  - 10: `{jalr_target[31:1], 1'b0}`.
  - 11: `{trap_vector[31:2], 2'b00}`.
- Alignment (no C extension):
  - For selects 00–10, the target is misaligned if bit 1 of the (masked) target is set.
  - A misaligned target is not loaded. `pc` <= `{trap_vector[31:2],2'b00}` and `misaligned_target` pulses for exactly the cycle after the `pc_update` edge.
  - Select 11 never raises `misaligned_target`.
- Arithmetic: all 32-bit, wrap modulo 2^32. `pc`=32'hFFFF_FFFC with select 00 gives 32'h0000_0000, no flag.
- Reset:
  - `pc`=`RESET_VECTOR`, state REQ, `inst`=0, `inst_valid`=0, `misaligned_target`=0.
  - `fetch_req_valid`=1 from the first cycle after reset deasserts.
  - Reset in any state abandons the outstanding request. Instruction memory shares `reset` and must drop it.

## Timing
- Request accept to WAIT: 1 cycle.
- Response to `inst_valid`=1: registered, visible the cycle after `fetch_rsp_valid`.
- `pc_update` to new `pc` and `fetch_req_valid`=1: visible the cycle after the `pc_update` edge.
- Minimum instruction period: 3 cycles (REQ, WAIT, HOLD), with `fetch_req_ready` and `fetch_rsp_valid` both high on first opportunity.
- Backpressure: `fetch_addr` must not change while `fetch_req_valid`=1 and `fetch_req_ready`=0, for any number of stall cycles.
- `inst_valid` and `misaligned_target` are never high in the same cycle.

## Test plan
- Reset sequencing:
  - Stimulus: reset 2 cycles, `fetch_req_ready`=1, response 1 cycle later with data 32'h0000_0013.
  - Required: `fetch_addr`=32'h0040_0000; `inst`=32'h13, `inst_valid`=1 on cycle 3.
  - Then `pc_update`, select 00 → `pc`=32'h0040_0004.
- Branch and JALR masking:
  - Stimulus: in HOLD, select 01 with `branch_target`=32'h0040_0100.
  - Required: `pc`=32'h0040_0100.
  - Stimulus: next, select 10 with `jalr_target`=32'h0040_0201.
  - Required: `pc`=32'h0040_0200, no flag.
- Misaligned jump:
  - Stimulus: select 10, `jalr_target`=32'h0040_0206, `trap_vector`=32'h0000_1003.
  - Required: `pc`=32'h0000_1000, `misaligned_target` high exactly 1 cycle.
- Backpressure and ignored events:
  - Stimulus: hold `fetch_req_ready`=0 for 5 cycles, pulsing `pc_update` and `fetch_rsp_valid` during REQ.
  - Required: `fetch_addr` stable, `pc` unchanged, no `inst_valid`.
- Wrap and mid-op reset:
  - Stimulus: `pc`=32'hFFFF_FFFC, select 00.
  - Required: `pc`=0, no flag.
  - Stimulus: assert reset while in WAIT.
  - Required: next cycle `pc`=`RESET_VECTOR`, state REQ, `inst_valid`=0.
